score_link_ctl: RTL and testbench

Controller for the two-player UART score link. It sits between the BCD score converter and the UART: it frames and sequences our 6-digit BCD score out through the transmitter and parses the opponent's frames from the receiver. It also owns the UART's write strobe and `rdy_clr` handshakes, so no other block drives the UART directly.

---
 rtl/score_link_pkg.sv | 42 ++++
 rtl/score_rx_parser.sv | 132 +++++++++++++
 rtl/score_link_ctl.sv | 99 +++++++++
 tb/tb_score_link_ctl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_link_pkg.sv
// Shared types, defaults and frame helpers for the two-player UART score link.
package score_link_pkg;

    localparam logic [7:0]  SYNC_DEFAULT    = 8'hA5;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;
    localparam int unsigned FRAME_LEN       = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP,
        TX_WAIT
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_HUNT,
        RX_B2,
        RX_B1,
        RX_B0,
        RX_CHK
    } rx_state_e;

    function automatic logic is_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // Byte idx of a frame: header, three score bytes MSB first, then XOR checksum.
    function automatic logic [7:0] frame_byte(input logic [7:0]  sync,
                                              input logic [23:0] score,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = score[23:16];
            3'd2:    b = score[15:8];
            3'd3:    b = score[7:0];
            default: b = score[23:16] ^ score[15:8] ^ score[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/score_rx_parser.sv
// Opponent frame parser: acknowledges UART bytes, tracks frame position,
// validates BCD digits and checksum, and aborts stalled frames on timeout.
module score_rx_parser
    import score_link_pkg::*;
#(
    parameter logic [7:0]  SYNC        = SYNC_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        pclk_i,
    input  logic        rst_i,
    input  logic        rx_rdy_i,
    input  logic [7:0]  rx_data_i,
    output logic        rdy_clr_o,
    output logic [23:0] opp_points_o,
    output logic        opp_valid_o,
    output logic        rx_err_o
);

    rx_state_e   state_q, state_d;
    logic [7:0]  b2_q, b2_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  b0_q, b0_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rdy_clr_q;
    logic [23:0] opp_q, opp_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        consume;
    logic        bad_digit;
    logic        is_sync;

    // A byte is taken only when the previous cycle did not already acknowledge it.
    assign consume   = rx_rdy_i && !rdy_clr_q;
    assign bad_digit = !is_bcd(rx_data_i);
    assign is_sync   = (rx_data_i == SYNC);

    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RX_HUNT;
            b2_q      <= '0;
            b1_q      <= '0;
            b0_q      <= '0;
            cnt_q     <= '0;
            rdy_clr_q <= 1'b0;
            opp_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            b2_q      <= b2_d;
            b1_q      <= b1_d;
            b0_q      <= b0_d;
            cnt_q     <= cnt_d;
            rdy_clr_q <= consume;
            opp_q     <= opp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        b2_d    = b2_q;
        b1_d    = b1_q;
        b0_d    = b0_q;
        cnt_d   = cnt_q;
        opp_d   = opp_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (consume) begin
            cnt_d = '0;
            case (state_q)
                RX_HUNT: begin
                    if (is_sync) state_d = RX_B2;
                end
                RX_B2: begin
                    b2_d = rx_data_i;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = is_sync ? RX_B2 : RX_HUNT;
                    end else begin
                        state_d = RX_B1;
                    end
                end
                RX_B1: begin
                    b1_d = rx_data_i;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = is_sync ? RX_B2 : RX_HUNT;
                    end else begin
                        state_d = RX_B0;
                    end
                end
                RX_B0: begin
                    b0_d = rx_data_i;
                    if (bad_digit) begin
                        err_d   = 1'b1;
                        state_d = is_sync ? RX_B2 : RX_HUNT;
                    end else begin
                        state_d = RX_CHK;
                    end
                end
                RX_CHK: begin
                    if (rx_data_i == (b2_q ^ b1_q ^ b0_q)) begin
                        opp_d   = {b2_q, b1_q, b0_q};
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = RX_HUNT;
                end
                default: state_d = RX_HUNT;
            endcase
        end else if (state_q != RX_HUNT) begin
            // Arriving bytes take priority, so the timeout is only judged on idle cycles.
            if (cnt_q == TIMEOUT_CYC - 16'd1) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                state_d = RX_HUNT;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign rdy_clr_o    = rdy_clr_q;
    assign opp_points_o = opp_q;
    assign opp_valid_o  = valid_q;
    assign rx_err_o     = err_q;

endmodule

// File: rtl/score_link_ctl.sv
// Score link controller: sequences our BCD score out through the UART
// transmitter and delegates opponent frame parsing to score_rx_parser.
module score_link_ctl
    import score_link_pkg::*;
#(
    parameter logic [7:0]  SYNC        = SYNC_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [23:0] points_bcd,
    input  logic        send_req,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        rdy_clr,
    output logic [23:0] opp_points,
    output logic        opp_valid,
    output logic        rx_err
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    tx_state_e   tx_state_q, tx_state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic        pend_q, pend_d;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            pend_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        // Requests outside idle coalesce into one pending frame.
        pend_d     = pend_q | (send_req && (tx_state_q != TX_IDLE));
        tx_wr      = 1'b0;
        tx_data    = 8'h00;

        case (tx_state_q)
            TX_IDLE: begin
                if (send_req || pend_q) begin
                    snap_d     = points_bcd;
                    pend_d     = 1'b0;
                    idx_d      = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_wr      = 1'b1;
                tx_data    = frame_byte(SYNC, snap_q, idx_q);
                tx_state_d = TX_GAP;
            end
            TX_GAP: begin
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        tx_state_d = TX_SEND;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    score_rx_parser #(
        .SYNC        (SYNC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx_parser (
        .pclk_i       (pclk),
        .rst_i        (rst),
        .rx_rdy_i     (rx_rdy),
        .rx_data_i    (rx_data),
        .rdy_clr_o    (rdy_clr),
        .opp_points_o (opp_points),
        .opp_valid_o  (opp_valid),
        .rx_err_o     (rx_err)
    );

endmodule

// File: tb/tb_score_link_ctl.sv
// Bench for score_link_ctl: UART emulation, directed and randomized frames,
// checked against a queue-based model of the link protocol.
module tb_score_link_ctl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 20;

    logic        pclk = 1'b0;
    logic        rst;
    logic [23:0] points_bcd;
    logic        send_req;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        rdy_clr;
    logic [23:0] opp_points;
    logic        opp_valid;
    logic        rx_err;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    score_link_ctl #(
        .SYNC        (SYNC),
        .TIMEOUT_CYC (16'd20)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .points_bcd (points_bcd),
        .send_req   (send_req),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rdy_clr    (rdy_clr),
        .opp_points (opp_points),
        .opp_valid  (opp_valid),
        .rx_err     (rx_err)
    );

    // UART emulation and event logging, all on the falling edge.
    int         cyc = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         n_wr = 0, n_valid = 0, n_err = 0, n_clr = 0;
    int         busy_len = 0;
    int         busy_left = 0;

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge pclk);
            cyc++;
            if (tx_wr === 1'b1) begin
                tx_log.push_back(tx_data);
                tx_cyc.push_back(cyc);
                n_wr++;
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            tx_busy = (busy_left > 0);
            if (opp_valid === 1'b1) n_valid++;
            if (rx_err === 1'b1)    n_err++;
            if (rdy_clr === 1'b1)   n_clr++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic [7:0]  exp_tx[$];
    logic        m_in = 1'b0;
    logic [7:0]  m_part[$];
    logic [23:0] m_opp = 24'h0;
    int          m_valid = 0, m_err = 0, m_clr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rnd_bcd();
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    function automatic logic [23:0] rnd_score();
        return {rnd_bcd(), rnd_bcd(), rnd_bcd()};
    endfunction

    task automatic push_frame(input logic [23:0] s);
        exp_tx.push_back(SYNC);
        exp_tx.push_back(s[23:16]);
        exp_tx.push_back(s[15:8]);
        exp_tx.push_back(s[7:0]);
        exp_tx.push_back(s[23:16] ^ s[15:8] ^ s[7:0]);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge pclk);
        send_req = 1'b0;
    endtask

    task automatic wait_quiet();
        int last, still, k;
        last = n_wr; still = 0; k = 0;
        while (still < 40 && k < 3000) begin
            @(negedge pclk);
            k++;
            if (n_wr != last) begin
                last  = n_wr;
                still = 0;
            end else begin
                still++;
            end
        end
        check("tx_quiet", 32'(still >= 40), 1);
    endtask

    task automatic tx_compare(input string tag);
        check({tag, "_len"}, tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            check(tag, tx_log[i], exp_tx[i]);
        tx_log.delete();
        tx_cyc.delete();
        exp_tx.delete();
    endtask

    // Send one byte as the UART would; the model predicts this byte's outcome.
    task automatic rx_byte(input logic [7:0] b, input int gap);
        logic        ev, ee;
        logic [23:0] eo;
        int          k;
        ev = 1'b0; ee = 1'b0;
        if (!m_in) begin
            if (b == SYNC) begin
                m_in = 1'b1;
                m_part.delete();
            end
        end else if (m_part.size() < 3) begin
            if (b[7:4] > 4'd9 || b[3:0] > 4'd9) begin
                ee = 1'b1;
                if (b == SYNC) m_part.delete();
                else m_in = 1'b0;
            end else begin
                m_part.push_back(b);
            end
        end else begin
            if (b == (m_part[0] ^ m_part[1] ^ m_part[2])) begin
                ev    = 1'b1;
                m_opp = {m_part[0], m_part[1], m_part[2]};
            end else begin
                ee = 1'b1;
            end
            m_in = 1'b0;
        end
        if (ev) m_valid++;
        if (ee) m_err++;
        m_clr++;
        eo = m_opp;

        repeat (gap) @(negedge pclk);
        rx_data = b;
        rx_rdy  = 1'b1;
        k = 0;
        do begin
            @(negedge pclk);
            k++;
        end while (rdy_clr !== 1'b1 && k < 10);
        rx_rdy = 1'b0;
        check("rx_ack_latency", k, 1);
        check("rx_opp_valid", opp_valid, ev);
        check("rx_err", rx_err, ee);
        check("rx_opp_points", opp_points, eo);
    endtask

    initial begin
        logic [23:0] s1, s2;
        logic [7:0]  d2, d1, d0, chk;
        int          k, kind, wr_mark;

        rst = 1'b1; points_bcd = '0; send_req = 1'b0; rx_rdy = 1'b0; rx_data = '0;
        repeat (3) @(negedge pclk);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_rdy_clr", rdy_clr, 0);
        check("rst_opp_points", opp_points, 24'h0);
        check("rst_opp_valid", opp_valid, 0);
        check("rst_rx_err", rx_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge pclk);

        // Basic frame with a slow transmitter; first byte one cycle after the request
        busy_len = 10;
        points_bcd = 24'h012345;
        push_frame(24'h012345);
        pulse_req();
        check("tx_first_wr", tx_wr, 1);
        check("tx_first_byte", tx_data, SYNC);
        wait_quiet();
        tx_compare("tx_basic");

        // Mid-frame score change and two coalesced requests
        points_bcd = 24'h012345;
        push_frame(24'h012345);
        push_frame(24'h000100);
        pulse_req();
        repeat (5) @(negedge pclk);
        points_bcd = 24'h000100;
        pulse_req();
        repeat (20) @(negedge pclk);
        pulse_req();
        wait_quiet();
        tx_compare("tx_coalesce");

        // Minimum byte spacing with an always-ready transmitter
        busy_len = 0;
        s1 = rnd_score();
        points_bcd = s1;
        push_frame(s1);
        pulse_req();
        wait_quiet();
        for (int i = 1; i < tx_cyc.size(); i++)
            check("tx_spacing", tx_cyc[i] - tx_cyc[i-1], 3);
        tx_compare("tx_spacing_data");

        // Request in the exact cycle the frame returns to idle
        s1 = rnd_score();
        s2 = rnd_score();
        points_bcd = s1;
        push_frame(s1);
        push_frame(s2);
        pulse_req();
        repeat (14) @(negedge pclk);
        points_bcd = s2;
        pulse_req();
        check("tx_exit_idle_gap", tx_wr, 0);
        @(negedge pclk);
        check("tx_exit_restart_wr", tx_wr, 1);
        check("tx_exit_restart_byte", tx_data, SYNC);
        wait_quiet();
        tx_compare("tx_exit_pending");

        // Randomized single frames with random transmitter latency
        for (int it = 0; it < 4; it++) begin
            busy_len = $urandom_range(0, 6);
            s1 = rnd_score();
            points_bcd = s1;
            push_frame(s1);
            pulse_req();
            repeat ($urandom_range(1, 4)) @(negedge pclk);
            points_bcd = rnd_score();
            wait_quiet();
            tx_compare("tx_random");
        end

        // Directed receive frames
        rx_byte(8'hA5, 2); rx_byte(8'h09, 2); rx_byte(8'h87, 2); rx_byte(8'h65, 2); rx_byte(8'hEB, 2);
        rx_byte(8'hA5, 2); rx_byte(8'h09, 2); rx_byte(8'h87, 2); rx_byte(8'h65, 2); rx_byte(8'h00, 2);
        rx_byte(8'hA5, 2); rx_byte(8'h12, 2); rx_byte(8'hA5, 2); rx_byte(8'h00, 2);
        rx_byte(8'h00, 2); rx_byte(8'h05, 2); rx_byte(8'h05, 2);

        // Timeout after silence inside a frame
        rx_byte(8'hA5, 2); rx_byte(8'h01, 2);
        k = 0;
        do begin
            @(negedge pclk);
            k++;
        end while (rx_err !== 1'b1 && k < 40);
        check("rx_timeout_delay", k, TMO);
        m_err++;
        m_in = 1'b0;

        // Byte arriving in the timeout cycle wins
        rx_byte(8'hA5, 2); rx_byte(8'h00, TMO - 1);
        rx_byte(8'h00, 2); rx_byte(8'h12, 2); rx_byte(8'h12, 2);

        // Randomized receive traffic
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            d2 = rnd_bcd(); d1 = rnd_bcd(); d0 = rnd_bcd();
            chk = d2 ^ d1 ^ d0;
            if (kind == 1) chk = chk ^ 8'($urandom_range(1, 255));
            if (kind == 2) begin
                k = $urandom_range(0, 2);
                if (k == 0)      d2 = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
                else if (k == 1) d1 = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
                else             d0 = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
            end
            if (kind == 3) begin
                rx_byte(8'($urandom), $urandom_range(1, 6));
            end else begin
                rx_byte(SYNC, $urandom_range(1, 6));
                rx_byte(d2, $urandom_range(1, 6));
                rx_byte(d1, $urandom_range(1, 6));
                rx_byte(d0, $urandom_range(1, 6));
                rx_byte(chk, $urandom_range(1, 6));
            end
        end
        rx_byte(SYNC, 2); rx_byte(8'h00, 2); rx_byte(8'h00, 2); rx_byte(8'h00, 2); rx_byte(8'h00, 2);
        repeat (3 * TMO) @(negedge pclk);
        check("rx_total_valid", n_valid, m_valid);
        check("rx_total_err", n_err, m_err);
        check("rx_total_clr", n_clr, m_clr);

        // Asynchronous reset in the middle of a transmitted frame
        rx_byte(8'hA5, 2); rx_byte(8'h09, 2); rx_byte(8'h87, 2); rx_byte(8'h65, 2); rx_byte(8'hEB, 2);
        busy_len = 10;
        points_bcd = 24'h012345;
        pulse_req();
        #2 rst = 1'b1;
        #1;
        check("arst_tx_wr", tx_wr, 0);
        check("arst_tx_data", tx_data, 8'h00);
        check("arst_opp_points", opp_points, 24'h0);
        check("arst_opp_valid", opp_valid, 0);
        check("arst_rx_err", rx_err, 0);
        check("arst_rdy_clr", rdy_clr, 0);
        wr_mark = n_wr;
        tx_log.delete();
        tx_cyc.delete();
        exp_tx.delete();
        m_in  = 1'b0;
        m_opp = 24'h0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        repeat (60) @(negedge pclk);
        check("arst_no_partial_tx", n_wr, wr_mark);

        // Transmit still works after reset
        busy_len = 3;
        points_bcd = 24'h000042;
        push_frame(24'h000042);
        pulse_req();
        wait_quiet();
        tx_compare("tx_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
